param_multicycle_alu: RTL and testbench

//  Parametrised multi-cycle ALU with valid/ready handshakes on operand and result sides.

---
 rtl/param_multicycle_alu.sv | 176 +++++++++++++++++
 tb/tb_param_multicycle_alu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_multicycle_alu.sv
// -----------------------------------------------------------------------------
// param_multicycle_alu
//
// Purpose:
//   Multi-cycle ALU with valid/ready handshakes on the operand side and the
//   result side. Operands are latched on an accepted handshake. Single-cycle
//   ops then spend one cycle in EXEC. MUL runs an iterative shift-add over
//   WIDTH cycles. The result is held in DONE until the consumer takes it. A
//   synchronous flush abandons any work in progress and returns to IDLE.
//
// Parameters:
//   WIDTH      operand width, 2..32 (default 8)
//
// Ports:
//   clk        in   1         rising-edge clock
//   reset_n    in   1         asynchronous active-low reset
//   in_valid   in   1         operands/op valid
//   in_ready   out  1         block can accept operands (IDLE only)
//   A          in   WIDTH     operand A, unsigned
//   B          in   WIDTH     operand B, unsigned
//   Op         in   3         operation select
//   flush      in   1         synchronous abort back to IDLE
//   out_valid  out  1         result valid, held until accepted
//   out_ready  in   1         consumer accepts result
//   Y          out  2*WIDTH   result
//   zero       out  1         Y == 0
//   ovf        out  1         signed overflow for ADD/SUB, else 0
//   busy       out  1         state != IDLE
//
// Op encoding:
//   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL
// -----------------------------------------------------------------------------
module param_multicycle_alu #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           Op,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 zero,
  output logic                 ovf,
  output logic                 busy
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [2:0]           op_reg;
  logic [SHW-1:0]       cnt;
  logic [2*WIDTH-1:0]   prod;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     shl_res;
  logic [WIDTH-1:0]     shr_res;
  logic [2*WIDTH-1:0]   alu_y;
  logic                 alu_ovf;
  logic [2*WIDTH-1:0]   prod_next;

  // The handshake and status outputs are decoded straight from the state
  // register, so they never depend combinationally on any input.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // The extra top bit of the widened add is the carry. In the widened
  // subtract it is the borrow, because it wraps to 1 whenever A < B.
  assign sum     = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff    = {1'b0, a_reg} - {1'b0, b_reg};
  assign shamt   = b_reg[SHW-1:0];
  assign shl_res = a_reg << shamt;
  assign shr_res = a_reg >> shamt;

  // The multiply works MSB-first (Horner form). The accumulator doubles each
  // step and adds A when the current multiplier bit is set. After WIDTH steps
  // it holds the full product.
  assign prod_next = {prod[2*WIDTH-2:0], 1'b0}
                   + (b_reg[cnt] ? {{WIDTH{1'b0}}, a_reg} : {(2*WIDTH){1'b0}});

  // Single-cycle result selection, evaluated on the latched operands
  always_comb begin
    alu_y   = '0;
    alu_ovf = 1'b0;
    case (op_reg)
      3'b000: begin
        alu_y   = {{(WIDTH-1){1'b0}}, sum};
        alu_ovf = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                  (sum[WIDTH-1] != a_reg[WIDTH-1]);
      end
      3'b001: begin
        alu_y   = {{(WIDTH-1){1'b0}}, diff};
        alu_ovf = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                  (diff[WIDTH-1] != a_reg[WIDTH-1]);
      end
      3'b010:  alu_y = {{WIDTH{1'b0}}, a_reg & b_reg};
      3'b011:  alu_y = {{WIDTH{1'b0}}, a_reg | b_reg};
      3'b100:  alu_y = {{WIDTH{1'b0}}, a_reg ^ b_reg};
      3'b101:  alu_y = {{WIDTH{1'b0}}, shl_res};
      3'b110:  alu_y = {{WIDTH{1'b0}}, shr_res};
      default: alu_y = '0;
    endcase
  end

  // Control FSM and datapath registers. Flush overrides everything else.
  // Y/zero/ovf are written only on the edge that enters DONE, so a flushed
  // operation leaves the previous result visible, but not qualified.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= '0;
      cnt    <= '0;
      prod   <= '0;
      Y      <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= Op;
            cnt    <= SHW'(WIDTH - 1);
            prod   <= '0;
            state  <= (Op == 3'b111) ? MUL : EXEC;
          end
        end
        EXEC: begin
          Y     <= alu_y;
          zero  <= (alu_y == '0);
          ovf   <= alu_ovf;
          state <= DONE;
        end
        MUL: begin
          prod <= prod_next;
          if (cnt == '0) begin
            Y     <= prod_next;
            zero  <= (prod_next == '0);
            ovf   <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt - SHW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_param_multicycle_alu
//
// Purpose:
//   Directed, self-checking bench for param_multicycle_alu. It uses a WIDTH=8
//   instance for most vectors and a WIDTH=4 instance for the small multiply.
//   Issued operations push their expected result into a queue. A separate
//   monitor pops and compares on every result handshake.
// -----------------------------------------------------------------------------
module tb_param_multicycle_alu;

  typedef struct {
    logic [15:0] y;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        zero;
  logic        ovf;
  logic        busy;

  logic        w4_in_valid;
  logic        w4_in_ready;
  logic [3:0]  w4_a;
  logic [3:0]  w4_b;
  logic [2:0]  w4_op;
  logic        w4_out_valid;
  logic [7:0]  w4_y;
  logic        w4_zero;
  logic        w4_ovf;
  logic        w4_busy;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [7:0]  q4[$];

  // Free-running clock with rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  param_multicycle_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Op        (op),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (y),
    .zero      (zero),
    .ovf       (ovf),
    .busy      (busy)
  );

  param_multicycle_alu #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (w4_in_valid),
    .in_ready  (w4_in_ready),
    .A         (w4_a),
    .B         (w4_b),
    .Op        (w4_op),
    .flush     (1'b0),
    .out_valid (w4_out_valid),
    .out_ready (1'b1),
    .Y         (w4_y),
    .zero      (w4_zero),
    .ovf       (w4_ovf),
    .busy      (w4_busy)
  );

  // Compare one value against its expectation and keep the tallies
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s got=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Issue one operation on the WIDTH=8 instance. When push is set, the
  // expected result goes to the scoreboard before the accept edge. When
  // exp_lat is nonzero, the task measures the edges from accept to out_valid.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] opv,
                               input logic [15:0] exp_y, input logic exp_ovf,
                               input int exp_lat, input bit push);
    int   edges;
    int   tries;
    exp_t e;
    tries = 0;
    do begin
      @(negedge clk);
      tries++;
    end while (!in_ready && tries < 50);
    checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = av;
    b = bv;
    op = opv;
    in_valid = 1'b1;
    if (push) begin
      e.y = exp_y;
      e.ovf = exp_ovf;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (exp_lat > 0) begin
      edges = 0;
      do begin
        @(posedge clk);
        edges++;
        #1;
      end while (!out_valid && edges < 40);
      checkOutput("latency", edges, exp_lat);
    end
  endtask

  // Scoreboard monitor for the WIDTH=8 instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result got Y=%0h required no result", y);
        end else begin
          e = sb.pop_front();
          checkOutput("result_y", {16'd0, y}, {16'd0, e.y});
          checkOutput("result_ovf", {31'd0, ovf}, {31'd0, e.ovf});
          checkOutput("result_zero", {31'd0, zero}, {31'd0, (e.y == 16'd0)});
        end
      end
    end
  end

  // Scoreboard monitor for the WIDTH=4 instance
  initial begin
    logic [7:0] e4;
    forever begin
      @(negedge clk);
      if (reset_n && w4_out_valid) begin
        if (q4.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL w4_unexpected_result got Y=%0h required no result", w4_y);
        end else begin
          e4 = q4.pop_front();
          checkOutput("w4_result_y", {24'd0, w4_y}, {24'd0, e4});
          checkOutput("w4_result_zero", {31'd0, w4_zero}, {31'd0, (e4 == 8'd0)});
        end
      end
    end
  end

  // Main directed sequence
  initial begin
    int   edges;
    logic seen;
    reset_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    op = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    w4_in_valid = 1'b0;
    w4_a = '0;
    w4_b = '0;
    w4_op = '0;

    #1;
    checkOutput("reset_y", {16'd0, y}, 32'd0);
    checkOutput("reset_flags", {28'd0, zero, ovf, out_valid, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-cycle operations
    applyStimulus(8'hFF, 8'h01, 3'b000, 16'h0100, 1'b0, 1, 1'b1);
    applyStimulus(8'h03, 8'h05, 3'b001, 16'h01FE, 1'b0, 1, 1'b1);
    applyStimulus(8'h80, 8'h01, 3'b001, 16'h007F, 1'b1, 1, 1'b1);
    applyStimulus(8'h7F, 8'h01, 3'b000, 16'h0080, 1'b1, 1, 1'b1);
    applyStimulus(8'hF0, 8'h3C, 3'b010, 16'h0030, 1'b0, 1, 1'b1);
    applyStimulus(8'hF0, 8'h0F, 3'b011, 16'h00FF, 1'b0, 1, 1'b1);
    applyStimulus(8'hAA, 8'hFF, 3'b100, 16'h0055, 1'b0, 1, 1'b1);
    applyStimulus(8'h5A, 8'h5A, 3'b100, 16'h0000, 1'b0, 1, 1'b1);
    applyStimulus(8'h01, 8'h0B, 3'b101, 16'h0008, 1'b0, 1, 1'b1);
    applyStimulus(8'h81, 8'h01, 3'b101, 16'h0002, 1'b0, 1, 1'b1);
    applyStimulus(8'h80, 8'h0F, 3'b110, 16'h0001, 1'b0, 1, 1'b1);

    // Multiplies take WIDTH edges
    applyStimulus(8'h00, 8'h55, 3'b111, 16'h0000, 1'b0, 8, 1'b1);
    applyStimulus(8'h0F, 8'h11, 3'b111, 16'h00FF, 1'b0, 8, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 3'b111, 16'hFE01, 1'b0, 8, 1'b1);

    // Flush mid-multiply: back to IDLE, no result, previous Y retained
    applyStimulus(8'h03, 8'h03, 3'b111, 16'h0000, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checkOutput("flush_mul_state", {30'd0, busy, out_valid}, 32'd0);
    checkOutput("flush_mul_y_kept", {16'd0, y}, 32'h0000FE01);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("flush_mul_no_valid", {31'd0, seen}, 32'd0);

    // Flush beats a simultaneous in_valid in IDLE
    @(negedge clk);
    a = 8'h01;
    b = 8'h02;
    op = 3'b000;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    checkOutput("flush_idle_no_accept", {30'd0, busy, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1 checkOutput("flush_idle_no_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset three steps into a multiply
    applyStimulus(8'h07, 8'h09, 3'b111, 16'h0000, 1'b0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 checkOutput("midreset_y", {16'd0, y}, 32'd0);
    checkOutput("midreset_state", {30'd0, out_valid, busy}, 32'd0);
    #2 reset_n = 1'b1;
    applyStimulus(8'h12, 8'h34, 3'b000, 16'h0046, 1'b0, 1, 1'b1);

    // Backpressure: result held, new operands ignored, then released
    @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(8'h00, 8'h00, 3'b000, 16'h0000, 1'b0, 1, 1'b1);
    a = 8'h05;
    b = 8'h05;
    op = 3'b000;
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1 checkOutput("hold", {13'd0, out_valid, in_ready, zero, y}, {13'd0, 1'b1, 1'b0, 1'b1, 16'h0000});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 checkOutput("hold_release_idle", {30'd0, busy, in_ready}, 32'd1);

    // WIDTH=4 multiply completes after edge 4
    @(negedge clk);
    w4_a = 4'hF;
    w4_b = 4'hF;
    w4_op = 3'b111;
    w4_in_valid = 1'b1;
    q4.push_back(8'hE1);
    @(posedge clk);
    #1 w4_in_valid = 1'b0;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (!w4_out_valid && edges < 40);
    checkOutput("w4_latency", edges, 4);

    repeat (4) @(posedge clk);
    #1 checkOutput("scoreboard_drained", sb.size() + q4.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
